// File: rtl/regfile_write_sequencer.sv
// Round-robin arbiter that shares the latch register file write port; each write runs SETUP/WRITE/HOLD.
// Optional write-through read forwarding is built when REGFILE_BYPASS_EN is defined.
module regfile_write_sequencer #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_sel,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               rf_we,
  output logic [AW-1:0]      rf_sel_in,
  output logic [DW-1:0]      rf_in,
  output logic               busy,
  input  logic [AW-1:0]      rd_sel1,
  input  logic [AW-1:0]      rd_sel2,
  input  logic [DW-1:0]      rf_o1,
  input  logic [DW-1:0]      rf_o2,
  output logic [DW-1:0]      o1,
  output logic [DW-1:0]      o2
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, HOLD} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          found;
  logic          arb;
  int            idx;

  // Scan upward from the pointer with wrap; the first requester found wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  assign arb = (state == IDLE || state == HOLD) && found;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arb) state_nx = SETUP;
      SETUP:   state_nx = WRITE;
      WRITE:   state_nx = HOLD;
      HOLD:    state_nx = arb ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Select and data only move on the edge into SETUP, so they are stable while rf_we is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      rf_we     <= 1'b0;
      rf_sel_in <= '0;
      rf_in     <= '0;
      busy      <= 1'b0;
    end else begin
      state <= state_nx;
      rf_we <= (state_nx == WRITE);
      busy  <= (state_nx != IDLE);
      if (arb) begin
        rf_sel_in <= req_sel[int'(win)*AW +: AW];
        rf_in     <= req_data[int'(win)*DW +: DW];
        gnt       <= NREQ'(1) << win;
        ptr       <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
      end else begin
        gnt <= '0;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd;

  // The latch only holds the new word once the write has completed, so forward until then.
  assign fwd = (state == SETUP) || (state == WRITE);
  assign o1  = (fwd && rd_sel1 == rf_sel_in) ? rf_in : rf_o1;
  assign o2  = (fwd && rd_sel2 == rf_sel_in) ? rf_in : rf_o2;
`else
  logic unused_rd_sel;

  assign unused_rd_sel = ^{rd_sel1, rd_sel2};
  assign o1 = rf_o1;
  assign o2 = rf_o2;
`endif

endmodule
